// File: rtl/gf_syndrome_bank.sv
// Bank of NCH GF(2^M) Horner accumulators that evaluate one received codeword
// at alpha^(FIRST_ROOT+j). The highest-order symbol arrives first.
module gf_syndrome_bank #(
    parameter int          M          = 5,
    parameter logic [M-1:0] POLY      = 5'b00101,
    parameter int          NCH        = 4,
    parameter int          FIRST_ROOT = 1,
    parameter int          NSYM       = 31,
    parameter int          CW         = 5
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             din_valid_i,
    input  logic [M-1:0]     din_i,
    input  logic             hold_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [NCH*M-1:0] syn_out_o,
    output logic [CW-1:0]    sym_cnt_o
);

    localparam int ORDER = (1 << M) - 1;

    // Multiply by alpha: shift up, and fold the overflowing x^M back in as POLY.
    function automatic logic [M-1:0] xtime(input logic [M-1:0] a);
        logic [M-1:0] s;
        s = {a[M-2:0], 1'b0};
        if (a[M-1])
            s = s ^ POLY;
        return s;
    endfunction

    function automatic logic [M-1:0] mul_alpha_pow(input logic [M-1:0] a, input int k);
        logic [M-1:0] r;
        r = a;
        for (int i = 0; i < ORDER; i++) begin
            if (i < k)
                r = xtime(r);
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NCH-1:0][M-1:0]  acc_q, acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   accept;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        accept  = (state_q == ACCUM) && din_valid_i && !hold_i && !start_i;
        // start overrides hold and restarts from any state
        if (start_i) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (accept) begin
            for (int j = 0; j < NCH; j++)
                acc_d[j] = mul_alpha_pow(acc_q[j], (FIRST_ROOT + j) % ORDER) ^ din_i;
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(NSYM))
                state_d = DONE;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o    = (state_q == ACCUM);
    assign done_o    = (state_q == DONE);
    assign syn_out_o = acc_q;
    assign sym_cnt_o = cnt_q;

endmodule
